// File: rtl/map_inflation_pkg.sv
// Shared constants, state encoding and cell packing for the map-inflation datapath.
package map_inflation_pkg;

    localparam int COORD_W = 4;
    localparam int MAP_W   = 16;
    localparam int MAP_H   = 16;
    localparam int RADIUS  = 1;
    localparam int CNT_W   = 4;
    localparam int DATA_W  = 2 * COORD_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    function automatic logic [DATA_W-1:0] pack_cell(input logic [COORD_W-1:0] y,
                                                    input logic [COORD_W-1:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/kernel_offset_cnt.sv
// Signed (dx,dy) walker over the square inflation kernel, row-major with dx innermost.
module kernel_offset_cnt #(
    parameter int RADIUS = 1,
    parameter int OFF_W  = 6
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clr,
    input  logic                    adv,
    output logic signed [OFF_W-1:0] dx,
    output logic signed [OFF_W-1:0] dy,
    output logic                    last
);

    localparam logic signed [OFF_W-1:0] R_POS = OFF_W'(RADIUS);
    localparam logic signed [OFF_W-1:0] R_NEG = -R_POS;
    localparam logic signed [OFF_W-1:0] ONE   = OFF_W'(1);

    assign last = (dx == R_POS) && (dy == R_POS);

    // Wrapping after the last position leaves the walker ready for the next obstacle.
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            dx <= R_NEG;
            dy <= R_NEG;
        end else if (adv) begin
            if (last) begin
                dx <= R_NEG;
                dy <= R_NEG;
            end else if (dx == R_POS) begin
                dx <= R_NEG;
                dy <= dy + ONE;
            end else begin
                dx <= dx + ONE;
            end
        end
    end

endmodule

// File: rtl/inflate_cell_gen.sv
// Expands one obstacle cell into its clipped inflation kernel and pushes each cell into the FIFO.
module inflate_cell_gen #(
    parameter int COORD_W = map_inflation_pkg::COORD_W,
    parameter int MAP_W   = map_inflation_pkg::MAP_W,
    parameter int MAP_H   = map_inflation_pkg::MAP_H,
    parameter int RADIUS  = map_inflation_pkg::RADIUS,
    parameter int CNT_W   = map_inflation_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 obs_valid,
    input  logic [COORD_W-1:0]   obs_x,
    input  logic [COORD_W-1:0]   obs_y,
    output logic                 obs_ready,
    input  logic                 fifo_full,
    output logic                 fifo_wr,
    output logic [2*COORD_W-1:0] fifo_data,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     cells_pushed
);

    import map_inflation_pkg::*;

    // Two guard bits let kernel positions go negative or past the map edge without wrapping.
    localparam int OFF_W = COORD_W + 2;
    localparam logic signed [OFF_W-1:0] MAP_W_S = OFF_W'(MAP_W);
    localparam logic signed [OFF_W-1:0] MAP_H_S = OFF_W'(MAP_H);

    state_t                    state_q, state_d;
    logic [COORD_W-1:0]        x_q, y_q;
    logic signed [OFF_W-1:0]   dx, dy, cx, cy;
    logic                      last, in_bounds, accept, advance, push;

    assign cx        = $signed({2'b00, x_q}) + dx;
    assign cy        = $signed({2'b00, y_q}) + dy;
    assign in_bounds = (state_q == ST_SCAN) && !cx[OFF_W-1] && (cx < MAP_W_S)
                       && !cy[OFF_W-1] && (cy < MAP_H_S);
    assign accept    = obs_valid && obs_ready;
    assign advance   = (state_q == ST_SCAN) && (!in_bounds || !fifo_full);
    assign push      = fifo_wr && !fifo_full;

    kernel_offset_cnt #(
        .RADIUS (RADIUS),
        .OFF_W  (OFF_W)
    ) u_offset (
        .clk  (clk),
        .rstn (rstn),
        .clr  (accept),
        .adv  (advance),
        .dx   (dx),
        .dy   (dy),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)          state_d = ST_SCAN;
            ST_SCAN: if (advance && last) state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // Write strobe and data depend only on registered state, so fifo_full never reaches fifo_wr.
    always_comb begin
        obs_ready = 1'b0;
        busy      = 1'b0;
        fifo_wr   = 1'b0;
        fifo_data = '0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: obs_ready = 1'b1;
            ST_SCAN: begin
                busy    = 1'b1;
                fifo_wr = in_bounds;
                if (in_bounds) fifo_data = {cy[COORD_W-1:0], cx[COORD_W-1:0]};
                done    = advance && last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            x_q          <= '0;
            y_q          <= '0;
            cells_pushed <= '0;
        end else if (accept) begin
            x_q          <= obs_x;
            y_q          <= obs_y;
            cells_pushed <= '0;
        end else if (push) begin
            cells_pushed <= cells_pushed + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_inflate_cell_gen.sv
// Scoreboard bench for inflate_cell_gen: a kernel model queues expected pushes, a monitor pops them.
module tb_inflate_cell_gen;

    localparam int RADIUS = 1;
    localparam int MAP_W  = 16;
    localparam int MAP_H  = 16;

    logic       clk, rstn, obs_valid, obs_ready, fifo_full, fifo_wr, busy, done;
    logic [3:0] obs_x, obs_y, cells_pushed;
    logic [7:0] fifo_data;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_d;

    inflate_cell_gen dut (
        .clk          (clk),
        .rstn         (rstn),
        .obs_valid    (obs_valid),
        .obs_x        (obs_x),
        .obs_y        (obs_y),
        .obs_ready    (obs_ready),
        .fifo_full    (fifo_full),
        .fifo_wr      (fifo_wr),
        .fifo_data    (fifo_data),
        .busy         (busy),
        .done         (done),
        .cells_pushed (cells_pushed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Every completed push must match the head of the expected queue.
    always @(negedge clk) begin
        if (rstn && fifo_wr && !fifo_full) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("[TB] FAIL unexpected_push got %h expected no push", fifo_data);
            end else begin
                exp_d = exp_q.pop_front();
                if (fifo_data !== exp_d) begin
                    errors = errors + 1;
                    $display("[TB] FAIL push_data got %h expected %h", fifo_data, exp_d);
                end
            end
        end
    end

    task automatic expect_cells(input int x, input int y, output int n);
        int cx, cy;
        n = 0;
        for (int ddy = -RADIUS; ddy <= RADIUS; ddy++) begin
            for (int ddx = -RADIUS; ddx <= RADIUS; ddx++) begin
                cx = x + ddx;
                cy = y + ddy;
                if (cx >= 0 && cx < MAP_W && cy >= 0 && cy < MAP_H) begin
                    exp_q.push_back({4'(cy), 4'(cx)});
                    n++;
                end
            end
        end
    endtask

    task automatic wait_ready(input string name);
        int g;
        g = 0;
        @(negedge clk);
        while (!obs_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (!obs_ready) begin
            checks++; errors++;
            $display("[TB] FAIL %s_ready_timeout got obs_ready=%b expected 1", name, obs_ready);
        end
    endtask

    task automatic check_idle(input string name, input int exp_cells);
        checks++;
        if (obs_ready !== 1'b1 || busy !== 1'b0 || fifo_wr !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_idle got ready=%b busy=%b wr=%b done=%b expected 1 0 0 0",
                     name, obs_ready, busy, fifo_wr, done);
        end
        checks++;
        if (cells_pushed !== 4'(exp_cells)) begin
            errors++;
            $display("[TB] FAIL %s_cells got %0d expected %0d", name, cells_pushed, exp_cells);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_missing_pushes got %0d left expected 0", name, exp_q.size());
        end
    endtask

    // One obstacle; optionally hold fifo_full for stall_len cycles once stall_push pushes completed.
    task automatic scan_obstacle(input string name, input int x, input int y,
                                 input int stall_push, input int stall_len, input int exp_cycles);
        int   n, cycles, pushes_done, stall_left;
        logic seen_done;
        wait_ready(name);
        expect_cells(x, y, n);
        obs_x = 4'(x); obs_y = 4'(y); obs_valid = 1'b1;
        @(posedge clk); #1 obs_valid = 1'b0;
        cycles = 0; pushes_done = 0; stall_left = stall_len; seen_done = 1'b0;
        for (int g = 0; g < 60 && !seen_done; g++) begin
            @(negedge clk);
            if (busy) cycles++;
            if (fifo_full) begin
                checks++;
                if (fifo_wr !== 1'b1 || exp_q.size() == 0 || fifo_data !== exp_q[0]) begin
                    errors++;
                    $display("[TB] FAIL %s_stall_hold got wr=%b data=%h expected wr=1 data=%h",
                             name, fifo_wr, fifo_data, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
                end
            end
            if (fifo_wr && !fifo_full) pushes_done++;
            if (done) seen_done = 1'b1;
            else begin
                @(posedge clk); #1;
                if (stall_left > 0 && pushes_done == stall_push) begin
                    fifo_full = 1'b1;
                    stall_left--;
                end else fifo_full = 1'b0;
            end
        end
        checks++;
        if (!seen_done || cycles != exp_cycles) begin
            errors++;
            $display("[TB] FAIL %s_scan_len got %0d cycles done=%b expected %0d cycles done=1",
                     name, cycles, seen_done, exp_cycles);
        end
        @(negedge clk);
        check_idle(name, n);
    endtask

    task automatic test_reset();
        rstn = 1'b0; obs_valid = 1'b0; obs_x = '0; obs_y = '0; fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_ready !== 1'b1 || fifo_wr !== 1'b0 || busy !== 1'b0 || done !== 1'b0
            || fifo_data !== 8'h00 || cells_pushed !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_state got ready=%b wr=%b busy=%b done=%b data=%h cells=%0d expected 1 0 0 0 00 0",
                     obs_ready, fifo_wr, busy, done, fifo_data, cells_pushed);
        end
        @(posedge clk); #1 rstn = 1'b1;
    endtask

    task automatic test_reset_mid_scan();
        int         n;
        logic [7:0] fourth;
        wait_ready("mid_reset");
        expect_cells(5, 5, n);
        fourth = exp_q[3];
        obs_x = 4'd5; obs_y = 4'd5; obs_valid = 1'b1;
        @(posedge clk); #1 obs_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (fifo_wr !== 1'b1 || fifo_data !== fourth) begin
            errors++;
            $display("[TB] FAIL mid_reset_fourth got wr=%b data=%h expected 1 %h", fifo_wr, fifo_data, fourth);
        end
        #1 rstn = 1'b0;
        exp_q.delete();
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        check_idle("mid_reset", 0);
        scan_obstacle("after_reset_2_2", 2, 2, 0, 0, 9);
    endtask

    task automatic test_back_to_back();
        int n, t1, t2, g;
        wait_ready("b2b");
        expect_cells(5, 5, n);
        obs_x = 4'd5; obs_y = 4'd5; obs_valid = 1'b1;
        t1 = cyc;
        @(posedge clk); #1;
        obs_x = 4'd8; obs_y = 4'd8;
        expect_cells(8, 8, n);
        g = 0;
        @(negedge clk);
        while (!obs_ready && g < 30) begin
            @(negedge clk);
            g++;
        end
        t2 = cyc;
        checks++;
        if (!obs_ready || t2 - t1 != 10) begin
            errors++;
            $display("[TB] FAIL b2b_spacing got %0d cycles ready=%b expected 10 ready=1", t2 - t1, obs_ready);
        end
        @(posedge clk); #1 obs_valid = 1'b0;
        g = 0;
        @(negedge clk);
        while (!done && g < 30) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL b2b_done_timeout got done=%b expected 1", done);
        end
        @(negedge clk);
        check_idle("b2b", n);
    endtask

    initial begin
        test_reset();
        scan_obstacle("centre_5_5", 5, 5, 0, 0, 9);
        scan_obstacle("corner_0_0", 0, 0, 0, 0, 9);
        scan_obstacle("corner_15_15", 15, 15, 0, 0, 9);
        scan_obstacle("stall_5_5", 5, 5, 1, 3, 12);
        test_reset_mid_scan();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
